// File: rtl/execute_mul_pipe_if.sv
// Issue-side, writeback, bypass and flush signals of the multiply execute unit.
// The execute unit connects through `master`; the surrounding core uses `slave`.
interface execute_mul_pipe_if #(
    parameter int XLEN             = 32,
    parameter int ROB_ID_WIDTH     = 7,
    parameter int PHY_REG_ID_WIDTH = 6
);
    logic                        issue_mul_fifo_data_out_valid;
    logic                        issue_mul_fifo_pop;
    logic [ROB_ID_WIDTH-1:0]     in_rob_id;
    logic [XLEN-1:0]             in_pc;
    logic                        in_has_exception;
    logic                        in_rd_enable;
    logic [PHY_REG_ID_WIDTH-1:0] in_rd_phy;
    logic [XLEN-1:0]             in_src1;
    logic [XLEN-1:0]             in_src2;
    logic [1:0]                  in_mul_op;

    logic                        mul_wb_port_we;
    logic                        mul_wb_port_full;
    logic                        mul_wb_port_flush;
    logic [ROB_ID_WIDTH-1:0]     wb_rob_id;
    logic [XLEN-1:0]             wb_pc;
    logic                        wb_has_exception;
    logic                        wb_rd_enable;
    logic [PHY_REG_ID_WIDTH-1:0] wb_rd_phy;
    logic [XLEN-1:0]             wb_rd_value;

    logic                        feedback_enable;
    logic [PHY_REG_ID_WIDTH-1:0] feedback_phy_id;
    logic [XLEN-1:0]             feedback_value;

    logic                        commit_flush;

    modport master (
        input  issue_mul_fifo_data_out_valid,
        output issue_mul_fifo_pop,
        input  in_rob_id, in_pc, in_has_exception, in_rd_enable, in_rd_phy,
        input  in_src1, in_src2, in_mul_op,
        output mul_wb_port_we,
        input  mul_wb_port_full,
        output mul_wb_port_flush,
        output wb_rob_id, wb_pc, wb_has_exception, wb_rd_enable, wb_rd_phy, wb_rd_value,
        output feedback_enable, feedback_phy_id, feedback_value,
        input  commit_flush
    );

    modport slave (
        output issue_mul_fifo_data_out_valid,
        input  issue_mul_fifo_pop,
        output in_rob_id, in_pc, in_has_exception, in_rd_enable, in_rd_phy,
        output in_src1, in_src2, in_mul_op,
        input  mul_wb_port_we,
        output mul_wb_port_full,
        input  mul_wb_port_flush,
        input  wb_rob_id, wb_pc, wb_has_exception, wb_rd_enable, wb_rd_phy, wb_rd_value,
        input  feedback_enable, feedback_phy_id, feedback_value,
        output commit_flush
    );
endinterface

// File: rtl/execute_mul_pipe.sv
// Pipelined RV32M multiply execute unit: the product is formed as an op enters stage 0
// and carried through STAGES registers with bubble collapse, writeback stall and flush.
module execute_mul_pipe #(
    parameter int XLEN             = 32,
    parameter int STAGES           = 3,
    parameter int ROB_ID_WIDTH     = 7,
    parameter int PHY_REG_ID_WIDTH = 6
) (
    input logic                clk,
    input logic                rst,
    execute_mul_pipe_if.master bus
);
    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mul_op_e;

    typedef struct packed {
        logic                        valid;
        logic [ROB_ID_WIDTH-1:0]     rob_id;
        logic [XLEN-1:0]             pc;
        logic                        has_exception;
        logic                        rd_enable;
        logic [PHY_REG_ID_WIDTH-1:0] rd_phy;
        logic [XLEN-1:0]             rd_value;
    } stage_t;

    stage_t            s [STAGES];
    stage_t            incoming;
    stage_t            last;
    logic [STAGES-1:0] adv;
    logic              pop;
    logic              we;
    logic              fb_en;

    mul_op_e           op;
    logic              signed_a;
    logic              signed_b;
    logic [2*XLEN-1:0] ext_a;
    logic [2*XLEN-1:0] ext_b;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   result;

    always_comb begin
        // NOTE: every variable of this block is assigned on every path, so no latch is inferred.
        op       = mul_op_e'(bus.in_mul_op);
        signed_a = (op == OP_MULH) || (op == OP_MULHSU);
        signed_b = (op == OP_MULH);
        ext_a    = {{XLEN{signed_a & bus.in_src1[XLEN-1]}}, bus.in_src1};
        ext_b    = {{XLEN{signed_b & bus.in_src2[XLEN-1]}}, bus.in_src2};
        // Low 2*XLEN bits of the extended product are exact for every signedness mix.
        product  = ext_a * ext_b;
        result   = (op == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        if (bus.in_has_exception) begin
            result = '0;
        end

        incoming.valid         = pop;
        incoming.rob_id        = bus.in_rob_id;
        incoming.pc            = bus.in_pc;
        incoming.has_exception = bus.in_has_exception;
        incoming.rd_enable     = bus.in_rd_enable;
        incoming.rd_phy        = bus.in_rd_phy;
        incoming.rd_value      = result;
    end

    // A stage holds only when it and every stage ahead of it are occupied and writeback is full.
    always_comb begin
        logic blocked;
        blocked = bus.mul_wb_port_full;
        for (int i = STAGES - 1; i >= 0; i--) begin
            blocked = blocked && s[i].valid;
            adv[i]  = !blocked;
        end
    end

    assign pop = bus.issue_mul_fifo_data_out_valid && adv[0] && !bus.commit_flush && !rst;

    always_ff @(posedge clk) begin
        // NOTE: only the valid bits are reset; payload is don't-care while valid is low
        // and every output below is gated by valid.
        if (rst || bus.commit_flush) begin
            for (int i = 0; i < STAGES; i++) begin
                s[i].valid <= 1'b0;
            end
        end else begin
            // NOTE: non-blocking assignments let each stage capture the pre-edge value of the one behind it.
            if (adv[0]) begin
                s[0] <= incoming;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i]) begin
                    s[i] <= s[i-1];
                end
            end
        end
    end

    assign last  = s[STAGES-1];
    assign we    = last.valid && !bus.mul_wb_port_full && !bus.commit_flush && !rst;
    assign fb_en = we && last.rd_enable && !last.has_exception;

    assign bus.issue_mul_fifo_pop = pop;
    assign bus.mul_wb_port_we     = we;
    assign bus.mul_wb_port_flush  = bus.commit_flush;

    assign bus.wb_rob_id        = last.valid ? last.rob_id        : '0;
    assign bus.wb_pc            = last.valid ? last.pc            : '0;
    assign bus.wb_has_exception = last.valid ? last.has_exception : 1'b0;
    assign bus.wb_rd_enable     = last.valid ? last.rd_enable     : 1'b0;
    assign bus.wb_rd_phy        = last.valid ? last.rd_phy        : '0;
    assign bus.wb_rd_value      = last.valid ? last.rd_value      : '0;

    assign bus.feedback_enable = fb_en;
    assign bus.feedback_phy_id = fb_en ? last.rd_phy   : '0;
    assign bus.feedback_value  = fb_en ? last.rd_value : '0;
endmodule

// File: tb/tb_execute_mul_pipe.sv
// Bench for execute_mul_pipe: three instances (STAGES 1, 3, 5) share one stimulus;
// directed sequences plus a randomized run against a queue-based reference model.
module tb_execute_mul_pipe;
    localparam int XLEN = 32;
    localparam int RW   = 7;
    localparam int PW   = 6;
    localparam int NDUT = 3;
    localparam int S3   = 1;  // index of the STAGES=3 instance

    typedef struct packed {
        logic            pop;
        logic            we;
        logic            flush;
        logic [RW-1:0]   rob_id;
        logic [XLEN-1:0] pc;
        logic            exc;
        logic            rd_en;
        logic [PW-1:0]   rd_phy;
        logic [XLEN-1:0] value;
        logic            fb_en;
        logic [PW-1:0]   fb_phy;
        logic [XLEN-1:0] fb_value;
    } out_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        exc;
        logic        rd_en;
        logic [31:0] exp_value;
        logic        exp_fb;
    } vec_t;

    typedef struct {
        logic [RW-1:0]   rob_id;
        logic [XLEN-1:0] pc;
        logic            exc;
        logic            rd_en;
        logic [PW-1:0]   rd_phy;
        logic [XLEN-1:0] value;
        int              t_pop;
    } inflight_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            fifo_valid, wb_full, flush, in_exc, in_rd_en;
    logic [RW-1:0]   in_rob;
    logic [XLEN-1:0] in_pc, src1, src2;
    logic [PW-1:0]   in_phy;
    logic [1:0]      in_op;
    out_t            outs [NDUT];
    int              st_of [NDUT] = '{1, 3, 5};
    int              total = 0;
    int              bad = 0;

    always #5 clk = ~clk;

    execute_mul_pipe_if #(.XLEN(XLEN), .ROB_ID_WIDTH(RW), .PHY_REG_ID_WIDTH(PW)) bus [NDUT] ();

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int STG = (g == 0) ? 1 : ((g == 1) ? 3 : 5);
        execute_mul_pipe #(
            .XLEN(XLEN), .STAGES(STG), .ROB_ID_WIDTH(RW), .PHY_REG_ID_WIDTH(PW)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus[g])
        );
        assign bus[g].issue_mul_fifo_data_out_valid = fifo_valid;
        assign bus[g].in_rob_id        = in_rob;
        assign bus[g].in_pc            = in_pc;
        assign bus[g].in_has_exception = in_exc;
        assign bus[g].in_rd_enable     = in_rd_en;
        assign bus[g].in_rd_phy        = in_phy;
        assign bus[g].in_src1          = src1;
        assign bus[g].in_src2          = src2;
        assign bus[g].in_mul_op        = in_op;
        assign bus[g].mul_wb_port_full = wb_full;
        assign bus[g].commit_flush     = flush;
        assign outs[g] = {bus[g].issue_mul_fifo_pop, bus[g].mul_wb_port_we, bus[g].mul_wb_port_flush,
                          bus[g].wb_rob_id, bus[g].wb_pc, bus[g].wb_has_exception, bus[g].wb_rd_enable,
                          bus[g].wb_rd_phy, bus[g].wb_rd_value, bus[g].feedback_enable,
                          bus[g].feedback_phy_id, bus[g].feedback_value};
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fifo_valid = 1'b0;
        in_rob = '0; in_pc = '0; in_exc = 1'b0; in_rd_en = 1'b0;
        in_phy = '0; src1 = '0; src2 = '0; in_op = 2'd0;
    endtask

    task automatic put(input logic [RW-1:0] rob, input logic [31:0] pc, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic exc,
                       input logic rd_en, input logic [PW-1:0] phy);
        fifo_valid = 1'b1;
        in_rob = rob; in_pc = pc; in_op = op; src1 = a; src2 = b;
        in_exc = exc; in_rd_en = rd_en; in_phy = phy;
    endtask

    // Reference arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic exc);
        longint      sa, sb, p;
        logic [63:0] up;
        if (exc) return 32'd0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0:    return up[31:0];
            2'd1:    begin p = sa * sb; return p[63:32]; end
            2'd2:    begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            default: return up[63:32];
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        vec_t        vecs [12];
        inflight_t   q [$];
        inflight_t   h;
        logic [1:0]  h_op;
        logic [31:0] h_a, h_b;
        logic [31:0] bp_a [4];
        logic [31:0] bp_b [4];
        logic        have_head;
        logic        exp_pop, exp_we, exp_fb, head_vis;
        int          j, vis_rob;

        rst = 1'b1; wb_full = 1'b0; flush = 1'b0;
        idle();
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) check($sformatf("reset_state_s%0d", st_of[g]), outs[g], '0);

        // Basic latency on every depth: mul 7x6, rob 3, rd_phy 5.
        step();
        put(7'd3, 32'h100, 2'd0, 32'd7, 32'd6, 1'b0, 1'b1, 6'd5);
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) check($sformatf("basic_pop_s%0d", st_of[g]), outs[g].pop, 1);
        for (int k = 1; k <= 6; k++) begin
            step(); idle();
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                check($sformatf("basic_we_s%0d_c%0d", st_of[g], k), outs[g].we, k == st_of[g]);
                if (k == st_of[g]) begin
                    check($sformatf("basic_value_s%0d", st_of[g]), outs[g].value, 42);
                    check($sformatf("basic_rob_s%0d", st_of[g]), outs[g].rob_id, 3);
                    check($sformatf("basic_fb_en_s%0d", st_of[g]), outs[g].fb_en, 1);
                    check($sformatf("basic_fb_phy_s%0d", st_of[g]), outs[g].fb_phy, 5);
                    check($sformatf("basic_fb_val_s%0d", st_of[g]), outs[g].fb_value, 42);
                end
            end
        end

        // Table of arithmetic / flag vectors streamed back-to-back through STAGES=3.
        vecs[0]  = '{2'd0, 32'd7,         32'd6,         1'b0, 1'b1, 32'd42,        1'b1};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
        vecs[2]  = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1};
        vecs[3]  = '{2'd2, 32'hFFFF_FFFF, 32'd2,         1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[4]  = '{2'd0, 32'h8000_0000, 32'd2,         1'b0, 1'b1, 32'h0000_0000, 1'b1};
        vecs[5]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h4000_0000, 1'b1};
        vecs[6]  = '{2'd2, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0001, 1'b1};
        vecs[7]  = '{2'd3, 32'h8000_0000, 32'd4,         1'b0, 1'b1, 32'h0000_0002, 1'b1};
        vecs[8]  = '{2'd0, 32'd7,         32'd6,         1'b1, 1'b1, 32'h0000_0000, 1'b0};
        vecs[9]  = '{2'd0, 32'd3,         32'd5,         1'b0, 1'b0, 32'd15,        1'b0};
        vecs[10] = '{2'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'h3FFF_FFFF, 1'b1};
        vecs[11] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0001, 1'b1};
        for (int k = 0; k < 15; k++) begin
            step();
            if (k < 12) put(7'(k), 32'h200 + 32'(k), vecs[k].op, vecs[k].a, vecs[k].b,
                            vecs[k].exc, vecs[k].rd_en, 6'(k + 1));
            else idle();
            @(negedge clk);
            if (k < 12) check($sformatf("tbl_pop_%0d", k), outs[S3].pop, 1);
            if (k >= 3) begin
                j = k - 3;
                check($sformatf("tbl_we_%0d", j), outs[S3].we, 1);
                check($sformatf("tbl_value_%0d", j), outs[S3].value, vecs[j].exp_value);
                check($sformatf("tbl_rob_%0d", j), outs[S3].rob_id, j);
                check($sformatf("tbl_exc_%0d", j), outs[S3].exc, vecs[j].exc);
                check($sformatf("tbl_fb_en_%0d", j), outs[S3].fb_en, vecs[j].exp_fb);
                check($sformatf("tbl_fb_phy_%0d", j), outs[S3].fb_phy, vecs[j].exp_fb ? j + 1 : 0);
                check($sformatf("tbl_fb_val_%0d", j), outs[S3].fb_value,
                      vecs[j].exp_fb ? vecs[j].exp_value : 32'd0);
            end
        end
        for (int k = 0; k < 8; k++) step();

        // Backpressure: A,B,C back-to-back, D waiting; full held 4 cycles from A's arrival.
        bp_a = '{32'd2, 32'hFFFF_0000, 32'h8000_0001, 32'd9};
        bp_b = '{32'd3, 32'h0001_0000, 32'h7FFF_FFFF, 32'd11};
        for (int k = 0; k < 12; k++) begin
            step();
            if (k <= 2) put(7'(10 + k), 32'h300 + 32'(k), 2'(k), bp_a[k], bp_b[k], 1'b0, 1'b1, 6'(k));
            else if (k <= 7) put(7'd13, 32'h303, 2'd3, bp_a[3], bp_b[3], 1'b0, 1'b1, 6'd3);
            else idle();
            wb_full = (k >= 3 && k <= 6);
            @(negedge clk);
            check($sformatf("bp_pop_c%0d", k), outs[S3].pop, (k <= 2) || (k == 7));
            check($sformatf("bp_we_c%0d", k), outs[S3].we, (k >= 7 && k <= 10));
            if (k >= 3 && k <= 10) begin
                vis_rob = (k <= 7) ? 10 : k + 3;
                check($sformatf("bp_rob_c%0d", k), outs[S3].rob_id, vis_rob);
                check($sformatf("bp_value_c%0d", k), outs[S3].value,
                      ref_mul(2'(vis_rob - 10), bp_a[vis_rob - 10], bp_b[vis_rob - 10], 1'b0));
            end
        end
        wb_full = 1'b0;
        for (int k = 0; k < 8; k++) step();

        // Flush: E,F in flight and G waiting; flush pulsed when E sits in the last stage.
        for (int k = 0; k < 9; k++) begin
            step();
            flush = (k == 3);
            if (k <= 1) put(7'(20 + k), 32'h400 + 32'(k), 2'd0, 32'(k + 2), 32'd5, 1'b0, 1'b1, 6'(k + 8));
            else if (k == 3 || k == 4) put(7'd22, 32'h422, 2'd0, 32'd6, 32'd7, 1'b0, 1'b1, 6'd12);
            else idle();
            @(negedge clk);
            if (k == 3) begin
                check("flush_pop", outs[S3].pop, 0);
                check("flush_out", outs[S3].flush, 1);
                check("flush_we", outs[S3].we, 0);
                check("flush_fb_en", outs[S3].fb_en, 0);
            end
            if (k == 4) begin
                check("post_flush_pop", outs[S3].pop, 1);
                check("post_flush_out", outs[S3].flush, 0);
            end
            if (k >= 4) check($sformatf("post_flush_we_c%0d", k), outs[S3].we, k == 7);
            if (k == 7) check("post_flush_rob", outs[S3].rob_id, 22);
            if (k == 7) check("post_flush_value", outs[S3].value, 42);
        end
        flush = 1'b0;
        for (int k = 0; k < 8; k++) step();

        // Reset with ops in flight on every depth.
        for (int k = 0; k < 9; k++) begin
            step();
            rst = (k == 3);
            if (k <= 2) put(7'(30 + k), 32'h500, 2'd0, 32'd3, 32'd3, 1'b0, 1'b1, 6'd1);
            else idle();
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                if (k == 4) check($sformatf("rst_mid_outs_s%0d", st_of[g]), outs[g], '0);
                if (k > 4) check($sformatf("rst_mid_we_s%0d_c%0d", st_of[g], k), outs[g].we, 0);
            end
        end

        // Randomized run on STAGES=3 against an in-order scoreboard. The oldest op reaches the
        // last stage exactly STAGES cycles after its pop, since nothing ahead of it can block it.
        have_head = 1'b0;
        for (int n = 0; n < 1510; n++) begin
            step();
            if (!have_head) begin
                h_op = 2'($urandom_range(3));
                h_a = pick();
                h_b = pick();
                h.rob_id = 7'($urandom());
                h.pc = $urandom();
                h.exc = ($urandom_range(7) == 0);
                h.rd_en = ($urandom_range(3) != 0);
                h.rd_phy = 6'($urandom());
                h.value = ref_mul(h_op, h_a, h_b, h.exc);
                have_head = 1'b1;
            end
            if (n < 1500) begin
                wb_full = ($urandom_range(2) == 0);
                flush = ($urandom_range(39) == 0);
                if ($urandom_range(3) != 0) put(h.rob_id, h.pc, h_op, h_a, h_b, h.exc, h.rd_en, h.rd_phy);
                else idle();
            end else begin
                wb_full = 1'b0;
                flush = 1'b0;
                idle();
            end
            @(negedge clk);
            exp_pop = fifo_valid && !flush && !(q.size() == st_of[S3] && wb_full);
            head_vis = 1'b0;
            if (q.size() > 0) head_vis = (n - q[0].t_pop) >= st_of[S3];
            exp_we = head_vis && !wb_full && !flush;
            check("rnd_pop", outs[S3].pop, exp_pop);
            check("rnd_we", outs[S3].we, exp_we);
            check("rnd_flush", outs[S3].flush, flush);
            if (head_vis) begin
                exp_fb = exp_we && q[0].rd_en && !q[0].exc;
                check("rnd_rob", outs[S3].rob_id, q[0].rob_id);
                check("rnd_pc", outs[S3].pc, q[0].pc);
                check("rnd_value", outs[S3].value, q[0].value);
                check("rnd_fb_en", outs[S3].fb_en, exp_fb);
                check("rnd_fb_val", outs[S3].fb_value, exp_fb ? q[0].value : 32'd0);
            end else begin
                check("rnd_idle_outs", {outs[S3].rob_id, outs[S3].value, outs[S3].fb_en}, '0);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (exp_we) void'(q.pop_front());
                if (exp_pop) begin
                    h.t_pop = n;
                    q.push_back(h);
                    have_head = 1'b0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/execute_mul_pipe.md
Name: execute_mul_pipe

Overview:
- Parametrised, pipelined multiply execute unit for the out-of-order core.
- Pops RV32M multiply ops (mul/mulh/mulhsu/mulhu) from its issue FIFO and carries them through STAGES register stages.
- Drives the result into a writeback port and the bypass feedback channel.
- Unlike the single-cycle ALU, it has configurable latency, writeback backpressure with bubble collapse, and a flush that kills in-flight ops.

Parameters:
- XLEN, 32, operand/result width.
- STAGES, 3, pipeline depth (≥1); issue-to-writeback latency in cycles.
- ROB_ID_WIDTH, 7, ROB index width.
- PHY_REG_ID_WIDTH, 6, physical register id width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_mul_fifo_data_out_valid  in  1  FIFO head valid
- issue_mul_fifo_pop  out  1  consume FIFO head this cycle
- in_rob_id  in  ROB_ID_WIDTH  ROB id of head
- in_pc  in  XLEN  PC of head
- in_has_exception  in  1  head carries an exception (pass-through)
- in_rd_enable  in  1  head writes rd
- in_rd_phy  in  PHY_REG_ID_WIDTH  destination physical reg
- in_src1, in_src2  in  XLEN each  operands
- in_mul_op  in  2  0=mul, 1=mulh, 2=mulhsu, 3=mulhu
- mul_wb_port_we  out  1  writeback entry valid this cycle
- mul_wb_port_full  in  1  writeback port cannot accept
- mul_wb_port_flush  out  1  flush request to writeback port
- wb_rob_id  out  ROB_ID_WIDTH  result ROB id
- wb_pc  out  XLEN  result PC
- wb_has_exception  out  1  result exception flag
- wb_rd_enable  out  1  result rd enable
- wb_rd_phy  out  PHY_REG_ID_WIDTH  result destination
- wb_rd_value  out  XLEN  result value
- feedback_enable  out  1  bypass broadcast valid
- feedback_phy_id  out  PHY_REG_ID_WIDTH  bypass destination
- feedback_value  out  XLEN  bypass value
- commit_flush  in  1  pipeline flush from commit

Behaviour:
- Clock and reset: single clk domain. rst is synchronous and active-high, sampled at the posedge.
- Reset state: all stage valid bits are 0, and every output is 0.
- Pipeline storage: stage registers s[0..STAGES-1], each holding a valid bit plus payload. Outputs are driven combinationally from s[STAGES-1].
- Stage advance: adv[STAGES-1] = !s[STAGES-1].valid || !mul_wb_port_full. For i<STAGES-1, adv[i] = !s[i].valid || adv[i+1]. Bubbles collapse, so an empty stage always accepts from the stage behind it.
- Pop: issue_mul_fifo_pop = issue_mul_fifo_data_out_valid && adv[0] && !commit_flush. A popped op enters s[0] at the next edge.
- Latency: with no stall, an op popped in cycle t is on the wb outputs in cycle t+STAGES.
- Writeback enable: mul_wb_port_we = s[STAGES-1].valid && !mul_wb_port_full && !commit_flush. The stage entry retires at the edge where we=1.
- Stall: an entry stalled by full holds all wb_* outputs stable until accepted.
- Flush: commit_flush=1 clears every stage valid bit at the next edge. In the same cycle, pop=0, we=0 and feedback_enable=0. mul_wb_port_flush = commit_flush (combinational).
- Flush priority: flush beats full, and flush beats a simultaneous pop.
- Arithmetic: compute the full 2·XLEN product, with operands sign- or zero-extended by op (mulh s×s, mulhsu s×u, mulhu u×u).
  - mul returns product[XLEN-1:0]; the others return product[2XLEN-1:XLEN].
  - The product may be computed in s[0] and carried through, or split across stages; the visible result is identical either way.
- Exceptions: if has_exception=1, wb_rd_value=0 and the op produces no feedback.
- Feedback: feedback_enable = mul_wb_port_we && wb_rd_enable && !wb_has_exception. When enabled, feedback_phy_id = wb_rd_phy and feedback_value = wb_rd_value; otherwise both are 0.
- Outputs with invalid last stage: when s[STAGES-1].valid=0, all wb_* data outputs are 0.
- Reset mid-operation: rst has priority over flush and pop. All in-flight ops are discarded with no writeback.

Test Plan:
- Basic latency (STAGES=3): pop mul 7×6 (rd_phy=5, rob 3) at cycle 10 -> we=1 at cycle 13 with wb_rd_value=42, rob_id=3; feedback_enable=1, phy_id=5, value=42.
- Signedness: mulh 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000; mulhu same operands -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF×2 -> 0xFFFFFFFF; mul 0x80000000×2 -> 0x00000000.
- Backpressure and collapse: 3 back-to-back pops with wb full held for 4 cycles from the first arrival.
  - The first result holds steady; pop deasserts once all stages fill.
  - After full drops, results emerge one per cycle in order, with none lost or duplicated.
- Flush: 2 ops in flight plus FIFO valid, commit_flush pulsed 1 cycle.
  - In that cycle: pop=0, mul_wb_port_flush=1, we=0.
  - Afterwards no writeback occurs for the killed ops; the next pop has normal latency.
- Exception and rd disable: has_exception=1 op -> we=1, wb_rd_value=0, feedback_enable=0. rd_enable=0 op -> we=1, feedback_enable=0.
- Reset: rst asserted with 3 ops in flight -> next cycle all outputs are 0. Repeat the basic latency scenario with STAGES=1 (latency 1) and STAGES=5 (latency 5).
